q_table_ram: RTL

Parametrised Q-table memory for the reinforcement-learning datapath: the successor to the fixed 64×16 action RAM. It stores one signed Q-value per (state, action) pair and clears itself to zero after reset. It provides a registered random-access read/write port for the update stage, plus a multi-cycle max-scan engine that returns max over a of Q(s,a) and its argmax for the policy/target stage. It sits between the agent controller (writes updated Q-values) and the action-selection / TD-target logic.

---
 rtl/q_ram_pkg.sv | 23 ++
 rtl/q_ram_mem.sv | 56 +++++
 rtl/q_table_ram.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/q_ram_pkg.sv
// Shared types and helpers for the Q-table memory.
// Holds the FSM encoding, default widths and a signed max function.
package q_ram_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int STATE_W_DEF = 6;
    localparam int ACT_W_DEF   = 2;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SCAN
    } q_ram_state_t;

    // Returns b only when it is strictly greater than a, so ties keep a.
    function automatic logic signed [31:0] s_max(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/q_ram_mem.sv
// 1W2R synchronous memory, write-first on both registered read ports.
// Ports: we/waddr/wdata write; re_x/raddr_x/rdata_x for reads A and B.
module q_ram_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re_a) begin
            rdata_a_d = (we && waddr == raddr_a) ? wdata : mem_q[raddr_a];
        end
        if (re_b) begin
            rdata_b_d = (we && waddr == raddr_b) ? wdata : mem_q[raddr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/q_table_ram.sv
// Q-table with self-clearing init, user R/W port and a max/argmax scan.
// Ports: en gates everything but init; ready after clear; max_* = scan.
module q_table_ram
    import q_ram_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int STATE_W = STATE_W_DEF,
    parameter int ACT_W   = ACT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               ready,
    input  logic               write_en,
    input  logic [STATE_W-1:0] wr_state,
    input  logic [ACT_W-1:0]   wr_action,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [STATE_W-1:0] rd_state,
    input  logic [ACT_W-1:0]   rd_action,
    output logic [DATA_W-1:0]  data_out,
    input  logic               max_start,
    input  logic [STATE_W-1:0] max_state,
    output logic               max_busy,
    output logic               max_done,
    output logic [DATA_W-1:0]  max_value,
    output logic [ACT_W-1:0]   max_action
);

    localparam int ADDR_W = STATE_W + ACT_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int EXT_W  = 32 - DATA_W;

    q_ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic [STATE_W-1:0]  scan_state_q, scan_state_d;
    logic [ACT_W:0]      act_cnt_q, act_cnt_d;
    logic                pend_q, pend_d;
    logic [ACT_W-1:0]    pend_act_q, pend_act_d;
    logic [DATA_W-1:0]   run_val_q, run_val_d;
    logic [ACT_W-1:0]    run_act_q, run_act_d;
    logic [DATA_W-1:0]   max_value_q, max_value_d;
    logic [ACT_W-1:0]    max_action_q, max_action_d;
    logic                max_done_q, max_done_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                re_a, re_b;
    logic [ADDR_W-1:0]   raddr_b;
    logic [DATA_W-1:0]   rdata_b;
    logic signed [31:0]  run_ext, cand_ext, mx;
    logic [DATA_W-1:0]   new_val;
    logic [ACT_W-1:0]    new_act;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        scan_state_d = scan_state_q;
        act_cnt_d    = act_cnt_q;
        pend_d       = pend_q;
        pend_act_d   = pend_act_q;
        run_val_d    = run_val_q;
        run_act_d    = run_act_q;
        max_value_d  = max_value_q;
        max_action_d = max_action_q;
        max_done_d   = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = {wr_state, wr_action};
        mem_wdata    = data_in;
        re_a         = 1'b0;
        re_b         = 1'b0;
        raddr_b      = {scan_state_q, act_cnt_q[ACT_W-1:0]};
        run_ext      = {{EXT_W{run_val_q[DATA_W-1]}}, run_val_q};
        cand_ext     = {{EXT_W{rdata_b[DATA_W-1]}}, rdata_b};
        mx           = s_max(run_ext, cand_ext);
        new_val      = run_val_q;
        new_act      = run_act_q;
        // Action 0 seeds the running max; later ones must beat it strictly.
        if (pend_act_q == '0 || mx != run_ext) begin
            new_val = rdata_b;
            new_act = pend_act_q;
        end

        unique case (state_q)
            INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (en) begin
                    mem_we = write_en;
                    re_a   = 1'b1;
                    if (max_start) begin
                        scan_state_d = max_state;
                        act_cnt_d    = '0;
                        pend_d       = 1'b0;
                        state_d      = SCAN;
                    end
                end
            end
            SCAN: begin
                if (en) begin
                    mem_we     = write_en;
                    re_a       = 1'b1;
                    // Top counter bit set means every action was issued.
                    re_b       = ~act_cnt_q[ACT_W];
                    pend_d     = ~act_cnt_q[ACT_W];
                    pend_act_d = act_cnt_q[ACT_W-1:0];
                    if (!act_cnt_q[ACT_W]) begin
                        act_cnt_d = act_cnt_q + 1'b1;
                    end
                    if (pend_q) begin
                        run_val_d = new_val;
                        run_act_d = new_act;
                        if (&pend_act_q) begin
                            max_value_d  = new_val;
                            max_action_d = new_act;
                            max_done_d   = 1'b1;
                            pend_d       = 1'b0;
                            state_d      = IDLE;
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            scan_state_q <= '0;
            act_cnt_q    <= '0;
            pend_q       <= 1'b0;
            pend_act_q   <= '0;
            run_val_q    <= '0;
            run_act_q    <= '0;
            max_value_q  <= '0;
            max_action_q <= '0;
            max_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            scan_state_q <= scan_state_d;
            act_cnt_q    <= act_cnt_d;
            pend_q       <= pend_d;
            pend_act_q   <= pend_act_d;
            run_val_q    <= run_val_d;
            run_act_q    <= run_act_d;
            max_value_q  <= max_value_d;
            max_action_q <= max_action_d;
            max_done_q   <= max_done_d;
        end
    end

    q_ram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .re_a    (re_a),
        .raddr_a ({rd_state, rd_action}),
        .rdata_a (data_out),
        .re_b    (re_b),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );

    assign ready      = (state_q != INIT);
    assign max_busy   = (state_q == SCAN);
    assign max_done   = max_done_q;
    assign max_value  = max_value_q;
    assign max_action = max_action_q;

endmodule
